// File: rtl/dcm_sp_obufds_tx.sv
// 7:1 LVDS panel transmitter: panel timing generation, RGB888 lane packing and
// serialisation onto four data lanes plus a forwarded clock lane, each as a _p/_n pair.
module dcm_sp_obufds_tx #(
    parameter int unsigned H_TOTAL  = 1440,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_TOTAL  = 823,
    parameter int unsigned V_ACTIVE = 800
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       new_pixel,
    output logic       ck1in_p,
    output logic       ck1in_n,
    output logic       rxin0_p,
    output logic       rxin0_n,
    output logic       rxin1_p,
    output logic       rxin1_n,
    output logic       rxin2_p,
    output logic       rxin2_n,
    output logic       rxin3_p,
    output logic       rxin3_n
);

    localparam int unsigned SLOT_W = 3;
    localparam int unsigned H_W    = 11;
    localparam int unsigned V_W    = 10;
    localparam int unsigned WORD_W = 7;
    localparam int unsigned LANES  = 4;

    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(WORD_W - 1);
    localparam logic [WORD_W-1:0] CLK_PATTERN = 7'b1100011;
    localparam logic [H_W-1:0]    H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT       = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]    V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT       = V_W'(V_ACTIVE);

    typedef struct packed {
        logic [WORD_W-1:0] lane3;
        logic [WORD_W-1:0] lane2;
        logic [WORD_W-1:0] lane1;
        logic [WORD_W-1:0] lane0;
    } lane_words_t;

    logic [SLOT_W-1:0] slot;
    logic [H_W-1:0]    hcount;
    logic [V_W-1:0]    vcount;
    lane_words_t       words;
    lane_words_t       words_next_c;
    logic              latch_c;
    logic              h_wrap_c;
    logic              hs_c;
    logic              vs_c;
    logic              de_c;
    logic [LANES-1:0]  data_bits_c;
    logic              clk_bit_c;

    assign latch_c  = (slot == SLOT_LAST);
    assign h_wrap_c = (hcount == H_LAST);
    assign hs_c     = (hcount < H_ACT);
    assign vs_c     = (vcount < V_ACT);
    assign de_c     = hs_c & vs_c;

    // Bit-slot counter within one 7-bit word.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (latch_c) begin
            slot <= '0;
        end else begin
            slot <= slot + SLOT_W'(1);
        end
    end

    // Pixel and line counters, stepped once per word.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (latch_c) begin
            if (h_wrap_c) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + V_W'(1);
            end else begin
                hcount <= hcount + H_W'(1);
            end
        end
    end

    // Lane packing; flags come from the pre-increment counters of this pixel.
    always_comb begin
        words_next_c       = '0;
        words_next_c.lane3 = {red[6], red[7], green[6], green[7], blue[6], blue[7], 1'b1};
        words_next_c.lane2 = {blue[2], blue[3], blue[4], blue[5], hs_c, vs_c, de_c};
        words_next_c.lane1 = {green[1], green[2], green[3], green[4], green[5], blue[0], blue[1]};
        words_next_c.lane0 = {red[0], red[1], red[2], red[3], red[4], red[5], green[0]};
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            words <= '0;
        end else if (latch_c) begin
            words <= words_next_c;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            new_pixel <= 1'b0;
        end else begin
            new_pixel <= latch_c;
        end
    end

    // Bit selection uses the pre-edge slot, so the pads lag the slot by one cycle.
    always_comb begin
        data_bits_c = '0;
        clk_bit_c   = 1'b0;
        data_bits_c = {words.lane3[slot], words.lane2[slot], words.lane1[slot], words.lane0[slot]};
        clk_bit_c   = CLK_PATTERN[slot];
    end

    // Both halves of every pair are flopped so _n is the exact complement even in reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ck1in_p <= 1'b0;
            ck1in_n <= 1'b1;
            rxin0_p <= 1'b0;
            rxin0_n <= 1'b1;
            rxin1_p <= 1'b0;
            rxin1_n <= 1'b1;
            rxin2_p <= 1'b0;
            rxin2_n <= 1'b1;
            rxin3_p <= 1'b0;
            rxin3_n <= 1'b1;
        end else begin
            ck1in_p <= clk_bit_c;
            ck1in_n <= ~clk_bit_c;
            rxin0_p <= data_bits_c[0];
            rxin0_n <= ~data_bits_c[0];
            rxin1_p <= data_bits_c[1];
            rxin1_n <= ~data_bits_c[1];
            rxin2_p <= data_bits_c[2];
            rxin2_n <= ~data_bits_c[2];
            rxin3_p <= data_bits_c[3];
            rxin3_n <= ~data_bits_c[3];
        end
    end

endmodule

// File: tb/tb_dcm_sp_obufds_tx.sv
// Directed bench for dcm_sp_obufds_tx using a reduced panel (12x6 total, 8x4 active)
// so that line and frame wraps are reachable in a short run.
module tb_dcm_sp_obufds_tx;

    localparam int unsigned HT = 12;
    localparam int unsigned HA = 8;
    localparam int unsigned VT = 6;
    localparam int unsigned VA = 4;

    logic       clk_in;
    logic       rst;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       new_pixel;
    logic       ck1in_p, ck1in_n;
    logic       rxin0_p, rxin0_n;
    logic       rxin1_p, rxin1_n;
    logic       rxin2_p, rxin2_n;
    logic       rxin3_p, rxin3_n;

    int compared;
    int mismatched;
    int k;              // rising edges since the last reset release
    logic [6:0] pat;

    dcm_sp_obufds_tx #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA)
    ) dut (
        .clk_in(clk_in), .rst(rst),
        .red(red), .green(green), .blue(blue),
        .new_pixel(new_pixel),
        .ck1in_p(ck1in_p), .ck1in_n(ck1in_n),
        .rxin0_p(rxin0_p), .rxin0_n(rxin0_n),
        .rxin1_p(rxin1_p), .rxin1_n(rxin1_n),
        .rxin2_p(rxin2_p), .rxin2_n(rxin2_n),
        .rxin3_p(rxin3_p), .rxin3_n(rxin3_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        k++;
        @(negedge clk_in);
    endtask

    // {hs, vs, de} of pixel index n counted from the first word after reset.
    function automatic logic [2:0] flags(int n);
        logic hs, vs;
        hs = ((n % HT) < HA);
        vs = (((n / HT) % VT) < VA);
        return {hs, vs, hs & vs};
    endfunction

    // Call with k a multiple of 7 (next edge transmits bit 0); returns the word and its pixel index.
    task automatic get_word(output logic [6:0] w0, output logic [6:0] w1,
                            output logic [6:0] w2, output logic [6:0] w3, output int n);
        n = (k - 7) / 7;
        for (int b = 0; b < 7; b++) begin
            step();
            w0[b] = rxin0_p;
            w1[b] = rxin1_p;
            w2[b] = rxin2_p;
            w3[b] = rxin3_p;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        compared++;
        if ({ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p} !== 5'b00000) begin
            mismatched++;
            $display("FAIL reset_p: got %b want 00000", {ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p});
        end
        compared++;
        if ({ck1in_n, rxin3_n, rxin2_n, rxin1_n, rxin0_n} !== 5'b11111) begin
            mismatched++;
            $display("FAIL reset_n: got %b want 11111", {ck1in_n, rxin3_n, rxin2_n, rxin1_n, rxin0_n});
        end
        compared++;
        if (new_pixel !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_new_pixel: got %b want 0", new_pixel);
        end
    endtask

    task automatic test_clock_lane();
        logic [4:0] pv;
        logic [4:0] nv;
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 21; i++) begin
            step();
            pv = {ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p};
            nv = {ck1in_n, rxin3_n, rxin2_n, rxin1_n, rxin0_n};
            compared++;
            if (ck1in_p !== pat[(k - 1) % 7]) begin
                mismatched++;
                $display("FAIL clock_lane k=%0d: got %b want %b", k, ck1in_p, pat[(k - 1) % 7]);
            end
            compared++;
            if (nv !== ~pv) begin
                mismatched++;
                $display("FAIL complement k=%0d: n=%b want %b", k, nv, ~pv);
            end
            compared++;
            if (new_pixel !== ((k % 7) == 0)) begin
                mismatched++;
                $display("FAIL first_new_pixel k=%0d: got %b want %b", k, new_pixel, (k % 7) == 0);
            end
            if (k <= 7) begin
                compared++;
                if (pv[3:0] !== 4'b0000) begin
                    mismatched++;
                    $display("FAIL data_before_latch k=%0d: got %b want 0000", k, pv[3:0]);
                end
            end
        end
    endtask

    task automatic test_new_pixel();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (new_pixel === 1'b1) begin
                pulses++;
                compared++;
                if ((k % 7) != 0) begin
                    mismatched++;
                    $display("FAIL new_pixel_phase k=%0d: got 1 want 0", k);
                end
            end
        end
        compared++;
        if (pulses != 10) begin
            mismatched++;
            $display("FAIL new_pixel_count: got %0d want 10", pulses);
        end
    endtask

    // red=01, green=blue=0 held since release.
    task automatic test_lane_pattern();
        int b, n;
        logic [2:0] f;
        for (int i = 0; i < 84; i++) begin
            step();
            b = (k - 1) % 7;
            n = (k - 8) / 7;
            f = flags(n);
            compared++;
            if ({rxin3_p, rxin2_p, rxin1_p, rxin0_p} !==
                {b == 0, (b < 3) ? f[b] : 1'b0, 1'b0, b == 6}) begin
                mismatched++;
                $display("FAIL lane_pattern k=%0d slot=%0d: got %b want %b", k, b,
                         {rxin3_p, rxin2_p, rxin1_p, rxin0_p},
                         {b == 0, (b < 3) ? f[b] : 1'b0, 1'b0, b == 6});
            end
        end
    endtask

    // Two different pixels latched on consecutive words.
    task automatic test_back_to_back();
        logic [6:0] w0, w1, w2, w3;
        int n;
        red = 8'hA5; green = 8'h3C; blue = 8'hC3;
        repeat (7) step();
        red = 8'h5A; green = 8'hC3; blue = 8'h3C;
        get_word(w0, w1, w2, w3, n);
        red = 8'h01; green = 8'h00; blue = 8'h00;
        compared++;
        if ({w3, w2, w1, w0} !== {7'b0100111, 4'b0000, flags(n), 7'b0111111, 7'b1010010}) begin
            mismatched++;
            $display("FAIL word_a: got %b_%b_%b_%b want %b_%b_%b_%b", w3, w2, w1, w0,
                     7'b0100111, {4'b0000, flags(n)}, 7'b0111111, 7'b1010010);
        end
        get_word(w0, w1, w2, w3, n);
        compared++;
        if ({w3, w2, w1, w0} !== {7'b1011001, 4'b1111, flags(n), 7'b1000000, 7'b0101101}) begin
            mismatched++;
            $display("FAIL word_b: got %b_%b_%b_%b want %b_%b_%b_%b", w3, w2, w1, w0,
                     7'b1011001, {4'b1111, flags(n)}, 7'b1000000, 7'b0101101);
        end
    endtask

    task automatic test_hblank();
        logic [6:0] w0, w1, w2, w3;
        int n, stage;
        stage = 0;
        for (int i = 0; i < 40 && stage < 2; i++) begin
            get_word(w0, w1, w2, w3, n);
            if (stage == 0 && (n % HT) == HA && ((n / HT) % VT) < VA) begin
                compared++;
                if ({w3, w2, w1, w0} !== {7'b0000001, 7'b0000010, 7'b0000000, 7'b1000000}) begin
                    mismatched++;
                    $display("FAIL hblank_first n=%0d: got %b_%b_%b_%b want 0000001_0000010_0000000_1000000",
                             n, w3, w2, w1, w0);
                end
                stage = 1;
            end else if (stage == 1 && (n % HT) == 0) begin
                compared++;
                if (w2 !== 7'b0000111) begin
                    mismatched++;
                    $display("FAIL hwrap n=%0d: got %b want 0000111", n, w2);
                end
                stage = 2;
            end
        end
        if (stage != 2) begin
            compared++;
            mismatched++;
            $display("FAIL hblank_timeout: stage %0d want 2", stage);
        end
    endtask

    task automatic test_vblank();
        logic [6:0] w0, w1, w2, w3;
        int n, stage;
        stage = 0;
        for (int i = 0; i < 80 && stage < 3; i++) begin
            get_word(w0, w1, w2, w3, n);
            if (stage == 0 && (n % HT) == 0 && ((n / HT) % VT) == VA) begin
                compared++;
                if (w2 !== 7'b0000100) begin
                    mismatched++;
                    $display("FAIL vblank_first n=%0d: got %b want 0000100", n, w2);
                end
                stage = 1;
            end else if (stage == 1 && (n % HT) == HT - 1 && ((n / HT) % VT) == VT - 1) begin
                compared++;
                if (w2 !== 7'b0000000) begin
                    mismatched++;
                    $display("FAIL frame_last n=%0d: got %b want 0000000", n, w2);
                end
                stage = 2;
            end else if (stage == 2) begin
                compared++;
                if (w2 !== 7'b0000111) begin
                    mismatched++;
                    $display("FAIL vwrap n=%0d: got %b want 0000111", n, w2);
                end
                stage = 3;
            end
        end
        if (stage != 3) begin
            compared++;
            mismatched++;
            $display("FAIL vblank_timeout: stage %0d want 3", stage);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [6:0] w0, w1, w2, w3;
        int n, hs_drop, vs_drop;
        for (int i = 0; i < 7 && (k % 7) != 3; i++) step();
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p, new_pixel} !== 6'b000000) begin
            mismatched++;
            $display("FAIL async_reset_p: got %b want 000000",
                     {ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p, new_pixel});
        end
        compared++;
        if ({ck1in_n, rxin3_n, rxin2_n, rxin1_n, rxin0_n} !== 5'b11111) begin
            mismatched++;
            $display("FAIL async_reset_n: got %b want 11111", {ck1in_n, rxin3_n, rxin2_n, rxin1_n, rxin0_n});
        end
        #1 rst = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            compared++;
            if ({ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p} !== {pat[i], 4'b0000}) begin
                mismatched++;
                $display("FAIL restart_slot k=%0d: got %b want %b", k,
                         {ck1in_p, rxin3_p, rxin2_p, rxin1_p, rxin0_p}, {pat[i], 4'b0000});
            end
        end
        hs_drop = -1;
        vs_drop = -1;
        for (int i = 0; i < 60 && vs_drop < 0; i++) begin
            get_word(w0, w1, w2, w3, n);
            if (hs_drop < 0 && w2[2] === 1'b0) hs_drop = i;
            if (vs_drop < 0 && w2[1] === 1'b0) vs_drop = i;
        end
        compared++;
        if (hs_drop != HA) begin
            mismatched++;
            $display("FAIL restart_hcount: first hs=0 word %0d want %0d", hs_drop, HA);
        end
        compared++;
        if (vs_drop != HT * VA) begin
            mismatched++;
            $display("FAIL restart_vcount: first vs=0 word %0d want %0d", vs_drop, HT * VA);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        k          = 0;
        pat        = 7'b1100011;
        rst        = 1'b0;
        red        = 8'h01;
        green      = 8'h00;
        blue       = 8'h00;
        #1;
        test_reset();
        test_clock_lane();
        test_new_pixel();
        test_lane_pattern();
        test_back_to_back();
        test_hblank();
        test_vblank();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dcm_sp_obufds_tx.md
# dcm_sp_obufds_tx

Single-clock LVDS panel transmitter, 7:1 serialisation. Takes one RGB888 pixel per 7 bit-clock cycles and generates the panel timing (active-region flags, data enable). Drives four serial data lanes plus a forwarded clock lane as complementary _p/_n pairs. It sits between the frame-buffer read logic and the FPGA's LVDS output pads; `clk_in` is already the bit-rate clock (7× pixel rate).

## Interface
- H_TOTAL, 1440: pixels per line, counted 0..H_TOTAL-1
- H_ACTIVE, 1280: active pixels per line, starting at pixel 0
- V_TOTAL, 823: lines per frame, counted 0..V_TOTAL-1
- V_ACTIVE, 800: active lines per frame, starting at line 0
- clk_in  in  1  bit clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- red, green, blue  in  8 each  pixel colour, sampled at word latch
- new_pixel  out  1  one-cycle pulse requesting the next pixel
- ck1in_p, ck1in_n  out  1 each  clock lane, differential pair
- rxin0_p/n .. rxin3_p/n  out  1 each  data lanes 0..3, differential pairs

## Operation
- Every _n output is the exact complement of its _p output at all times, including during reset.
- slot: 3-bit counter 0..6. It increments every cycle and wraps 6→0.
- hcount (11 b) and vcount (10 b) advance on the edge where slot==6:
  - hcount wraps at H_TOTAL-1 to 0.
  - On that wrap, vcount increments, wrapping at V_TOTAL-1 to 0.
- Flags for the current pixel:
  - hs = hcount < H_ACTIVE
  - vs = vcount < V_ACTIVE
  - de = hs & vs
- Word latch on the edge where slot==6: capture red/green/blue and hs/vs/de (evaluated on pre-increment counters) into four 7-bit lane words:
  - lane3 = {r6,r7,g6,g7,b6,b7,1}
  - lane2 = {b2,b3,b4,b5,hs,vs,de}
  - lane1 = {g1,g2,g3,g4,g5,b0,b1}
  - lane0 = {r0,r1,r2,r3,r4,r5,g0}
- Listed MSB first (bit6..bit0). Slot s transmits bit[s], so bit0 goes first and bit6 last.
- Clock lane pattern is the constant 7'b1100011, bit[s] per slot. Sequence from slot 0: 1,1,0,0,0,1,1.
- new_pixel is registered: it goes high on the edge where slot==6 and stays high for exactly the one cycle with slot==0.
  - Upstream must present the next pixel before the following slot-6 edge.
  - RGB is ignored at all other times.

## Timing
- Serial output flops: on each edge, each lane's _p register takes word[slot], using the pre-edge slot. Output latency is one cycle after the slot value.
- Reset (asynchronous, active-high) sets:
  - slot=0, hcount=0, vcount=0
  - lane words = 0
  - new_pixel=0
  - all _p outputs 0 and all _n outputs 1
- The first edge after reset release transmits slot-0 bits. Data lanes send zeros until the first latch at the 7th edge; the clock lane runs its pattern immediately.
- One pixel takes 7 cycles, one line H_TOTAL×7 cycles, one frame H_TOTAL×V_TOTAL×7 cycles.
- Reset asserted mid-word aborts the word immediately; there is no partial-word completion.
- Counter wrap and latch happen on the same edge. The latched flags belong to the pixel before the wrap.

## Test plan
- Reset held, then released:
  - during reset, all _p = 0, all _n = 1, new_pixel = 0
  - after release, ck1in_p shows 1,1,0,0,0,1,1 repeating with period 7
  - every _n equals ~_p on every cycle
- Free-run 70 cycles: new_pixel is high exactly one cycle in every 7, first on the cycle after the 7th edge.
- red=8'h01, green=8'h00, blue=8'h00 held:
  - from the second word on, rxin0_p = 1 only in slot 6
  - rxin1_p = 0 throughout
  - rxin3_p = 1 only in slot 0
  - rxin2_p = 1 in slots 0..2 (hs, vs, de all high at pixel 0)
- Advance to pixel 1280 on line 0: lane2 bits 0 and 2 (de, hs) = 0 and bit 1 (vs) = 1. At pixel 1439 the next word is pixel 0 with hs = 1 again.
- Advance to line 800: vs = 0 and de = 0 for all pixels. After line 822, pixel 1439, the next word is line 0 with vs = 1.
- Assert rst in slot 3 for a partial cycle:
  - outputs go to reset values asynchronously
  - after release, slot restarts at 0 and hcount/vcount restart at 0
